// File: rtl/hzd_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hzd_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_sequencer.sv
// Occupancy sequencer for the shared mult/div unit: tracks busy time and
// emits a registered completion pulse on the return to RUN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | unit idle; a start strobe is accepted at the next edge
//   MD_BUSY | unit occupied; md_cnt counts down to 0, then back to RUN
module md_sequencer
  import hzd_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic accept_i,
  input  logic op_i,
  output logic busy_o,
  output logic done_o
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (accept_i) begin
          state_d  = MD_BUSY;
          md_cnt_d = op_i ? DIV_CNT : MUL_CNT;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = done_q;

endmodule

// File: rtl/hazard_controller.sv
// ID-stage hazard decode: load-use and mult/div stalls, branch flush,
// mult/div start sequencing and a saturating stall-cycle counter.
module hazard_controller
  import hzd_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RtAddr_i,
  input  logic [4:0]       IFID_RsAddr_i,
  input  logic [4:0]       IFID_RtAddr_i,
  input  logic             Branch_taken_i,
  input  logic             MD_start_i,
  input  logic             MD_op_i,
  input  logic             HILO_read_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IDEX_bubble_o,
  output logic             IFID_flush_o,
  output logic             MD_go_o,
  output logic             MD_busy_o,
  output logic             MD_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             load_use, md_stall, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    load_use = IDEX_MemRead_i && (IDEX_RtAddr_i != REG_ZERO) &&
               ((IDEX_RtAddr_i == IFID_RsAddr_i) || (IDEX_RtAddr_i == IFID_RtAddr_i));
    md_stall = MD_busy_o && (MD_start_i || HILO_read_i);
    stall    = load_use || md_stall;
  end

  // Branch operands may come from the stalled load, so a stall wins over flush.
  assign PC_write_o    = ~stall;
  assign IFID_write_o  = ~stall;
  assign IDEX_bubble_o = stall;
  assign IFID_flush_o  = Branch_taken_i & ~stall;
  assign MD_go_o       = ~MD_busy_o & MD_start_i & ~load_use;

  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_seq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .accept_i (MD_go_o),
    .op_i     (MD_op_i),
    .busy_o   (MD_busy_o),
    .done_o   (MD_done_o)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
